dso_capture_ctrl: RTL and testbench
===================================

Name: dso_capture_ctrl

Overview:
- Capture controller at the other end of the trigger handshake in the DSO datapath.
- Drives trig_en, armed and set_capture_done into the trigger block, and consumes its sticky triggered flag.
- Writes decimated samples into a circular capture RAM, retaining a programmable number of post-trigger samples.
- Reports the trace end address to the host readout logic.

Parameters:
- ENTRIES, 384, depth of the circular capture RAM in samples.
- AW, 9, width of the address and counter fields. Must satisfy 2**AW >= ENTRIES.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse: begin a capture. Ignored outside IDLE.
- smpl_en  input  1  decimated sample strobe; one RAM write per high cycle while capturing
- trig_pos  input  AW  number of post-trigger samples to keep; latched on start
- triggered  input  1  sticky trigger flag from the trigger block
- rd_done  input  1  one-cycle pulse: host finished reading the trace
- trig_en  output  1  trigger detection enable to the trigger block
- armed  output  1  enough pre-trigger samples held; trigger may fire
- set_capture_done  output  1  one-cycle pulse that clears triggered
- we  output  1  capture RAM write enable
- waddr  output  AW  capture RAM write address
- trace_end  output  AW  address of the last sample written in the completed capture
- capture_done  output  1  status bit; high while a completed trace awaits readout

Behaviour:
- Reset:
  - state=IDLE; waddr=0; trace_end=0.
  - Internal counters smpl_cnt and post_cnt = 0; latched trig_pos register = 0.
  - All 1-bit outputs 0.
- States are IDLE, CAPTURE, POST and DONE.
- IDLE:
  - trig_en=0, armed=0, we=0.
  - On start: latch trig_pos, clamped to ENTRIES-1 if larger.
  - On start: clear waddr, smpl_cnt and post_cnt, then go to CAPTURE.
- Write rule:
  - In CAPTURE or POST, we = smpl_en combinationally.
  - waddr presents the current write address in that cycle.
  - waddr increments on the next clock, wrapping ENTRIES-1 -> 0.
- CAPTURE:
  - trig_en=1.
  - smpl_cnt increments per write and saturates at ENTRIES.
  - armed is registered. It rises the cycle after the write that makes smpl_cnt >= ENTRIES - trig_pos_lat, and stays high until DONE.
  - If triggered=1 while armed=1, go to POST the next cycle.
  - If triggered=1 while armed=0, it is a stale flag: ignore it and stay in CAPTURE.
  - A write in the same cycle as the transition still occurs and counts as pre-trigger.
- POST:
  - trig_en=1, armed=1.
  - post_cnt increments per write.
  - If trig_pos_lat=0: pulse set_capture_done on POST entry, set trace_end = waddr-1 mod ENTRIES, then go to DONE with no post writes.
  - Otherwise, on the write where post_cnt reaches trig_pos_lat: set_capture_done=1 for exactly one cycle, trace_end=waddr of that write, then go to DONE.
- DONE:
  - trig_en=0, armed=0, we=0, capture_done=1.
  - start is ignored.
  - rd_done returns to IDLE; capture_done falls the next cycle.
- Simultaneous events:
  - rd_done outside DONE is ignored.
  - start together with rd_done in DONE: rd_done wins; start is not queued.
- Trigger latency: the trigger block's three-flop synchroniser delays triggered by at least 3 clocks. Samples in that window are pre-trigger; trig_pos compensation is software's job.
- Reset mid-capture: abort immediately to reset values. No set_capture_done pulse is generated, so the trigger block's own reset clears triggered.

Decomposition:
- dso_pkg holds:
  - the state enum cap_state_t with values IDLE, CAPTURE, POST and DONE;
  - the default ENTRIES and AW localparams.
- One sub-module, dso_wrap_cnt: AW-bit counter with clear, increment and wrap at ENTRIES-1. It is instantiated for waddr.
- smpl_cnt and post_cnt stay inline.

Test Plan:
- ENTRIES=8, trig_pos=3, smpl_en every cycle:
  - armed rises the cycle after the 5th write (waddr 4);
  - triggered forced high 2 cycles later -> exactly 3 POST writes;
  - set_capture_done is a single pulse; trace_end equals the last waddr; capture_done=1.
- Wrap: ENTRIES=8, trig_pos=2, trigger after 13 writes -> waddr sequence 0..7,0..6 with no gap; trace_end=6.
- Stale trigger: triggered held high from start -> no POST entry before armed=1; POST is entered the cycle after armed rises.
- trig_pos=0 and trig_pos=500 (clamped to ENTRIES-1):
  - trig_pos=0 gives zero post writes and trace_end = last pre-trigger waddr;
  - trig_pos=500 gives ENTRIES-1 post writes and armed after 1 write.
- smpl_en 1-in-4 duty -> we matches smpl_en exactly, counts advance only on strobes, and set_capture_done coincides with the final strobe.
- Async reset in POST, then start and rd_done while in DONE:
  - reset: all outputs 0 with no clock edge;
  - start in DONE is ignored;
  - rd_done returns to IDLE and capture_done falls the next cycle.

Source files
------------

// File: rtl/dso_pkg.sv
// Shared types and default sizing for the DSO capture path.
package dso_pkg;

    localparam int unsigned DSO_ENTRIES = 384;
    localparam int unsigned DSO_AW      = 9;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        POST,
        DONE
    } cap_state_t;

endpackage

// File: rtl/dso_wrap_cnt.sv
// Capture RAM address counter: clear, increment, wrap at ENTRIES-1.
module dso_wrap_cnt
    import dso_pkg::*;
#(
    parameter int unsigned ENTRIES = DSO_ENTRIES,
    parameter int unsigned AW      = DSO_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [AW-1:0] cnt
);

    localparam logic [AW-1:0] LAST = AW'(ENTRIES - 1);

    // Address register; clear has priority over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dso_capture_ctrl.sv
// Capture controller: fills the circular capture RAM around a trigger and
// hands the completed trace to the host readout logic.
module dso_capture_ctrl
    import dso_pkg::*;
#(
    parameter int unsigned ENTRIES = DSO_ENTRIES,
    parameter int unsigned AW      = DSO_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          smpl_en,
    input  logic [AW-1:0] trig_pos,
    input  logic          triggered,
    input  logic          rd_done,
    output logic          trig_en,
    output logic          armed,
    output logic          set_capture_done,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [AW-1:0] trace_end,
    output logic          capture_done
);

    localparam logic [AW-1:0] TP_MAX = AW'(ENTRIES - 1);
    localparam logic [AW:0]   ENT_W  = (AW + 1)'(ENTRIES);

    cap_state_t    state;
    logic [AW-1:0] tp_lat;
    logic [AW-1:0] post_cnt;
    logic [AW:0]   smpl_cnt;
    logic [AW:0]   smpl_cnt_nxt;
    logic [AW:0]   arm_thr;
    logic [AW-1:0] tp_clamp;
    logic [AW-1:0] waddr_prev;
    logic          tp_zero;
    logic          post_last;
    logic          wr_clr;

    dso_wrap_cnt #(
        .ENTRIES (ENTRIES),
        .AW      (AW)
    ) u_waddr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (wr_clr),
        .inc   (we),
        .cnt   (waddr)
    );

    // Write strobe, completion pulse and derived counter values.
    always_comb begin
        tp_clamp     = (trig_pos > TP_MAX) ? TP_MAX : trig_pos;
        tp_zero      = (tp_lat == '0);
        smpl_cnt_nxt = (smpl_cnt == ENT_W) ? smpl_cnt : smpl_cnt + 1'b1;
        arm_thr      = ENT_W - {1'b0, tp_lat};
        waddr_prev   = (waddr == '0) ? TP_MAX : waddr - 1'b1;
        wr_clr       = (state == IDLE) && start;

        we = 1'b0;
        if (state == CAPTURE) begin
            we = smpl_en;
        end else if (state == POST && !tp_zero) begin
            we = smpl_en;
        end

        post_last        = (state == POST) && we && ((post_cnt + 1'b1) == tp_lat);
        set_capture_done = (state == POST) && (tp_zero || post_last);
    end

    // Capture sequencing with registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            tp_lat       <= '0;
            post_cnt     <= '0;
            smpl_cnt     <= '0;
            trace_end    <= '0;
            trig_en      <= 1'b0;
            armed        <= 1'b0;
            capture_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        tp_lat   <= tp_clamp;
                        smpl_cnt <= '0;
                        post_cnt <= '0;
                        trig_en  <= 1'b1;
                        armed    <= 1'b0;
                        state    <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (smpl_en) begin
                        smpl_cnt <= smpl_cnt_nxt;
                        if (smpl_cnt_nxt >= arm_thr) begin
                            armed <= 1'b1;
                        end
                    end
                    // A trigger seen before arming is left over from an earlier run.
                    if (triggered && armed) begin
                        state <= POST;
                    end
                end
                POST: begin
                    if (tp_zero) begin
                        trace_end    <= waddr_prev;
                        trig_en      <= 1'b0;
                        armed        <= 1'b0;
                        capture_done <= 1'b1;
                        state        <= DONE;
                    end else if (we) begin
                        post_cnt <= post_cnt + 1'b1;
                        if (post_last) begin
                            trace_end    <= waddr;
                            trig_en      <= 1'b0;
                            armed        <= 1'b0;
                            capture_done <= 1'b1;
                            state        <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (rd_done) begin
                        capture_done <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dso_capture_ctrl.sv
// Randomized bench for dso_capture_ctrl against a sample-count reference model.
module tb_dso_capture_ctrl;

    localparam int unsigned E  = 8;
    localparam int unsigned AW = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          smpl_en = 1'b0;
    logic [AW-1:0] trig_pos = '0;
    logic          triggered = 1'b0;
    logic          rd_done = 1'b0;
    logic          trig_en;
    logic          armed;
    logic          set_capture_done;
    logic          we;
    logic [AW-1:0] waddr;
    logic [AW-1:0] trace_end;
    logic          capture_done;

    dso_capture_ctrl #(
        .ENTRIES (E),
        .AW      (AW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .smpl_en          (smpl_en),
        .trig_pos         (trig_pos),
        .triggered        (triggered),
        .rd_done          (rd_done),
        .trig_en          (trig_en),
        .armed            (armed),
        .set_capture_done (set_capture_done),
        .we               (we),
        .waddr            (waddr),
        .trace_end        (trace_end),
        .capture_done     (capture_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: phase 0 idle, 1 pre-trigger, 2 post-trigger, 3 trace held.
    int ph      = 0;
    int n_wr    = 0;   // writes since start; address = n_wr mod E
    int n_post  = 0;
    int tp      = 0;
    int m_armed = 0;
    int m_te    = 0;
    int since   = 0;   // cycles spent armed before the current one

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        ph = 0; n_wr = 0; n_post = 0; tp = 0; m_armed = 0; m_te = 0; since = 0;
    endtask

    task automatic check_outputs();
        logic ewe, escd;
        ewe  = ((ph == 1) || (ph == 2 && tp != 0)) && smpl_en;
        escd = (ph == 2) && (tp == 0 || (smpl_en && n_post + 1 == tp));
        check("we", we, ewe);
        check("waddr", waddr, n_wr % E);
        check("trig_en", trig_en, (ph == 1 || ph == 2));
        check("armed", armed, (ph == 1 || ph == 2) && m_armed != 0);
        check("set_capture_done", set_capture_done, escd);
        check("trace_end", trace_end, m_te);
        check("capture_done", capture_done, ph == 3);
    endtask

    task automatic model_step();
        int arm_now;
        case (ph)
            0: if (start) begin
                tp = (trig_pos > E - 1) ? int'(E - 1) : int'(trig_pos);
                n_wr = 0; n_post = 0; m_armed = 0; since = 0; ph = 1;
            end
            1: begin
                arm_now = m_armed;
                if (arm_now != 0) since++;
                if (smpl_en) begin
                    n_wr++;
                    if (n_wr >= int'(E) - tp) m_armed = 1;
                end
                if (arm_now != 0 && triggered) ph = 2;
            end
            2: begin
                if (tp == 0) begin
                    m_te = (n_wr + E - 1) % E; m_armed = 0; ph = 3;
                end else if (smpl_en) begin
                    n_post++;
                    if (n_post == tp) begin
                        m_te = n_wr % E; m_armed = 0; ph = 3;
                    end
                    n_wr++;
                end
            end
            default: if (rd_done) ph = 0;
        endcase
    endtask

    task automatic tick();
        #1 check_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // duty 0 = random strobe, otherwise one strobe every duty cycles.
    task automatic do_capture(input int tp_in, input int duty, input int stale,
                              input int w, input int exp_te, input int abort_post);
        int cyc;
        int posts;
        bit trig_h;
        start = 1'b0; rd_done = 1'b1; smpl_en = 1'($urandom % 2); triggered = 1'b0;
        tick();
        rd_done = 1'b0;
        trig_pos = AW'(tp_in);
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0; posts = 0; trig_h = 0;
        while (ph != 3 && cyc < 2000) begin
            if (abort_post > 0 && ph == 2 && n_post >= abort_post) begin
                #2 rst_n = 1'b0;
                #1;
                model_reset();
                check("rst_we", we, 0);
                check("rst_waddr", waddr, 0);
                check("rst_trig_en", trig_en, 0);
                check("rst_armed", armed, 0);
                check("rst_set_capture_done", set_capture_done, 0);
                check("rst_trace_end", trace_end, 0);
                check("rst_capture_done", capture_done, 0);
                triggered = 1'b0; start = 1'b0; rd_done = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                tick();
                return;
            end
            smpl_en = (duty <= 0) ? 1'($urandom % 2) : ((cyc % duty) == 0);
            if (m_armed != 0 && since >= w) trig_h = 1;
            triggered = (stale != 0) || trig_h;
            start = ($urandom % 8) == 0;
            rd_done = ($urandom % 8) == 0;
            #1;
            if (ph == 2 && we) posts++;
            tick();
            cyc++;
        end
        check("capture_budget", ph == 3, 1);
        triggered = 1'b0; start = 1'b0; rd_done = 1'b0;
        check("post_writes", posts, tp);
        if (exp_te >= 0) check("trace_end_value", trace_end, exp_te);
        repeat ($urandom_range(1, 3)) begin
            start = 1'($urandom % 2);
            smpl_en = 1'($urandom % 2);
            tick();
        end
        start = 1'b1; rd_done = 1'b1;
        tick();
        start = 1'b0; rd_done = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        model_reset();
        #12;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        do_capture(3,   1, 0, 2, 2, 0);
        do_capture(2,   1, 0, 6, 6, 0);
        do_capture(3,   1, 1, 0, 0, 0);
        do_capture(0,   1, 0, 0, 0, 0);
        do_capture(500, 1, 0, 0, 0, 0);
        do_capture(3,   4, 0, 3, -1, 0);
        repeat (12) begin
            do_capture($urandom_range(0, 10), $urandom_range(0, 3), $urandom % 2,
                       $urandom_range(0, 5), -1, 0);
        end
        do_capture(5, 1, 0, 1, -1, 2);
        do_capture($urandom_range(0, 7), 0, 0, 2, -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
